scu_dsp_dma_responder: RTL and testbench

- SCU-side responder for the DSP DMA initiator interface.
- Holds the DSP read/write address registers (RA0/WA0), loaded from the DSP D1 bus output.
- Services each single-word DMA request from the DSP with one bus access on the SCU memory port, then returns ACK, read data, and end-of-block to the DSP.
- Sits between the DSP core and the SCU A/B-bus/WRAM arbiter.

---
 rtl/scu_dsp_dma_responder.sv | 117 +++++++++++
 tb/tb_scu_dsp_dma_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scu_dsp_dma_responder.sv
// scu_dsp_dma_responder: SCU-side responder for DSP DMA; one memory access per DSP request.
// Define SCU_DSP_DMA_TIMEOUT_EN to abort a stalled bus access after TIMEOUT CE cycles and flag ERR.
module scu_dsp_dma_responder #(
  parameter int AW = 25,
  parameter int TIMEOUT = 255
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CE,
  input  logic [31:0]   DSP_DSO,
  input  logic          DSP_RA0W,
  input  logic          DSP_WA0W,
  input  logic          DSP_DMA_REQ,
  input  logic          DSP_DMA_WE,
  input  logic [31:0]   DSP_DMA_DO,
  input  logic          DSP_DMA_RUN,
  input  logic          DSP_DMA_LAST,
  output logic          DSP_DMA_ACK,
  output logic [31:0]   DSP_DMA_DI,
  output logic          DSP_DMA_END,
  output logic [AW+1:0] MEM_A,
  output logic [31:0]   MEM_DO,
  output logic          MEM_RD,
  output logic          MEM_WR,
  input  logic [31:0]   MEM_DI,
  input  logic          MEM_ACK,
  output logic          ERR
);
  typedef enum logic [1:0] {IDLE, BUS, ACK, ENDS} state_t;
  state_t state;
  logic [AW-1:0] ra0, wa0;
  logic [31:0] wdata;
  logic pend, dir, lastl, abt, inc, tmo, unused_ok;
  assign inc = state == BUS && MEM_ACK;
  assign unused_ok = &{1'b0, DSP_DSO, TIMEOUT[0]};
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      ra0 <= '0;
      wa0 <= '0;
      wdata <= '0;
      pend <= 1'b0;
      dir <= 1'b0;
      lastl <= 1'b0;
      abt <= 1'b0;
      MEM_A <= '0;
      MEM_DO <= '0;
      MEM_RD <= 1'b0;
      MEM_WR <= 1'b0;
      DSP_DMA_ACK <= 1'b0;
      DSP_DMA_DI <= '0;
      DSP_DMA_END <= 1'b0;
    end else if (CE) begin
      ra0 <= DSP_RA0W ? DSP_DSO[AW-1:0] : inc && !dir ? ra0 + AW'(1) : ra0;
      wa0 <= DSP_WA0W ? DSP_DSO[AW-1:0] : inc && dir ? wa0 + AW'(1) : wa0;
      DSP_DMA_ACK <= 1'b0;
      DSP_DMA_END <= 1'b0;
      if (DSP_DMA_REQ && !pend && state == IDLE) begin
        pend <= 1'b1;
        dir <= DSP_DMA_WE;
        lastl <= DSP_DMA_LAST;
        wdata <= DSP_DMA_DO;
      end
      // a RUN drop anywhere in the transfer suppresses the DSP handshake, even if RUN returns
      if (state != IDLE && !DSP_DMA_RUN) abt <= 1'b1;
      case (state)
        IDLE: begin
          abt <= 1'b0;
          if (pend) begin
            state <= BUS;
            pend <= 1'b0;
            MEM_A <= {dir ? wa0 : ra0, 2'b00};
            MEM_DO <= wdata;
            MEM_RD <= !dir;
            MEM_WR <= dir;
          end
        end
        BUS: begin
          if (MEM_ACK || tmo) begin
            MEM_RD <= 1'b0;
            MEM_WR <= 1'b0;
            DSP_DMA_DI <= !MEM_ACK ? '0 : dir ? DSP_DMA_DI : MEM_DI;
            if (abt || !DSP_DMA_RUN) begin
              state <= IDLE;
              pend <= 1'b0;
            end else begin
              state <= ACK;
              DSP_DMA_ACK <= 1'b1;
            end
          end
        end
        ACK: begin
          state <= lastl && DSP_DMA_RUN && !abt ? ENDS : IDLE;
          DSP_DMA_END <= lastl && DSP_DMA_RUN && !abt;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef SCU_DSP_DMA_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign tmo = state == BUS && !MEM_ACK && cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
      ERR <= 1'b0;
    end else if (CE) begin
      cnt <= state == BUS ? cnt + CW'(1) : '0;
      if (tmo) ERR <= 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
  assign ERR = 1'b0;
`endif
endmodule

// File: tb/tb_scu_dsp_dma_responder.sv
// tb_scu_dsp_dma_responder: scoreboard bench; stimulus queues expected memory/ACK/END events, a monitor pops them.
module tb_scu_dsp_dma_responder;
  logic CLK = 0, RST = 1, CE = 1;
  logic [31:0] DSP_DSO = 0, DSP_DMA_DO = 0, DSP_DMA_DI, MEM_DO, MEM_DI = 0;
  logic DSP_RA0W = 0, DSP_WA0W = 0, DSP_DMA_REQ = 0, DSP_DMA_WE = 0, DSP_DMA_RUN = 1, DSP_DMA_LAST = 0;
  logic DSP_DMA_ACK, DSP_DMA_END, MEM_RD, MEM_WR, MEM_ACK = 0, ERR;
  logic [26:0] MEM_A;

  scu_dsp_dma_responder #(.AW(25), .TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .DSP_DSO(DSP_DSO), .DSP_RA0W(DSP_RA0W), .DSP_WA0W(DSP_WA0W),
    .DSP_DMA_REQ(DSP_DMA_REQ), .DSP_DMA_WE(DSP_DMA_WE), .DSP_DMA_DO(DSP_DMA_DO),
    .DSP_DMA_RUN(DSP_DMA_RUN), .DSP_DMA_LAST(DSP_DMA_LAST), .DSP_DMA_ACK(DSP_DMA_ACK),
    .DSP_DMA_DI(DSP_DMA_DI), .DSP_DMA_END(DSP_DMA_END), .MEM_A(MEM_A), .MEM_DO(MEM_DO),
    .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .MEM_DI(MEM_DI), .MEM_ACK(MEM_ACK), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {int k; logic [31:0] a; logic [31:0] d; int w;} ev_t;
  ev_t q[$];
  int checks = 0, fails = 0;
  int ce_div = 1, ce_cnt = 0;
  int ack_delay = 1, bus_n = 0, no_ack = 0;
  logic [31:0] rdata = 0;
  logic ce_s;
  logic p_str = 0, p_ack = 0, p_end = 0;
  int sw = 0, aw = 0, ew = 0, w_exp = -1;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask

  task automatic ex(int k, logic [31:0] a, logic [31:0] d, int w);
    ev_t e;
    e.k = k; e.a = a; e.d = d; e.w = w;
    q.push_back(e);
  endtask

  task automatic got(int k, logic [31:0] a, logic [31:0] d);
    ev_t e;
    if (q.size() == 0) begin
      checks++; fails++;
      $display("FAIL unexpected_event kind=%0d addr=%h data=%h", k, a, d);
    end else begin
      e = q.pop_front();
      chk("event_kind", 32'(k), 32'(e.k));
      if (k < 2) begin
        chk("mem_addr", a, e.a);
        chk("mem_data", d, e.d);
        w_exp = e.w;
      end
      if (k == 2) chk("ack_di", d, e.d);
    end
  endtask

  always @(negedge CLK) begin
    ce_cnt = (ce_cnt + 1) % ce_div;
    CE = ce_cnt == 0;
  end

  // memory model: raises MEM_ACK once the strobe has been seen for ack_delay CE edges
  always @(posedge CLK) begin
    ce_s = CE;
    #1;
    if (!(MEM_RD || MEM_WR)) bus_n = 0;
    else if (ce_s) bus_n++;
    MEM_ACK = no_ack == 0 && bus_n != 0 && bus_n >= ack_delay;
    MEM_DI = rdata;
  end

  always @(posedge CLK) begin
    #2;
    if (RST) begin
      p_str = 0; p_ack = 0; p_end = 0; sw = 0; aw = 0; ew = 0;
    end else begin
      if ((MEM_RD || MEM_WR) && !p_str) got(MEM_WR ? 1 : 0, 32'(MEM_A), MEM_DO);
      if (DSP_DMA_ACK && !p_ack) got(2, 0, DSP_DMA_DI);
      if (DSP_DMA_END && !p_end) got(3, 0, 0);
      if (MEM_RD || MEM_WR) sw++;
      else begin
        if (p_str && w_exp >= 0) chk("strobe_width", 32'(sw), 32'(w_exp));
        sw = 0;
      end
      if (DSP_DMA_ACK) aw++;
      else begin
        if (p_ack) chk("ack_width", 32'(aw), 32'(ce_div));
        aw = 0;
      end
      if (DSP_DMA_END) ew++;
      else begin
        if (p_end) chk("end_width", 32'(ew), 32'(ce_div));
        ew = 0;
      end
      p_str = MEM_RD || MEM_WR; p_ack = DSP_DMA_ACK; p_end = DSP_DMA_END;
    end
  end

  task automatic tick();
    do @(posedge CLK); while (!CE);
    @(negedge CLK);
  endtask

  task automatic load(bit wa, logic [31:0] v);
    DSP_DSO = v;
    if (wa) DSP_WA0W = 1; else DSP_RA0W = 1;
    tick();
    DSP_WA0W = 0; DSP_RA0W = 0;
  endtask

  task automatic req(bit we, bit last, logic [31:0] d);
    DSP_DMA_WE = we; DSP_DMA_LAST = last; DSP_DMA_DO = d; DSP_DMA_REQ = 1;
    tick();
    DSP_DMA_REQ = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() > 0; i++) @(negedge CLK);
    chk("drain_timeout", 32'(q.size()), 0);
    q.delete();
    tick(); tick();
  endtask

  task automatic pulse_rst();
    RST = 1;
    repeat (2) @(negedge CLK);
    RST = 0;
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_mem_a", 32'(MEM_A), 0);
    chk("rst_mem_do", MEM_DO, 0);
    chk("rst_strobes", {30'd0, MEM_RD, MEM_WR}, 0);
    chk("rst_ack_end", {30'd0, DSP_DMA_ACK, DSP_DMA_END}, 0);
    chk("rst_di", DSP_DMA_DI, 0);
    chk("rst_err", 32'(ERR), 0);
    RST = 0;
    tick();
    // single read with RA0 load
    load(0, 32'h0001_2345);
    ack_delay = 2; rdata = 32'hDEAD_BEEF;
    ex(0, 32'h0048D14, 0, 2); ex(2, 0, 32'hDEAD_BEEF, 0); ex(3, 0, 0, 0);
    req(0, 1, 0);
    drain();
    ack_delay = 1; rdata = 32'h1111_1111;
    ex(0, 32'h0048D18, 0, 1); ex(2, 0, 32'h1111_1111, 0);
    req(0, 0, 0);
    drain();
    // 4-word write burst; DI must keep the last read value
    load(1, 32'h100);
    for (int i = 1; i <= 4; i++) begin
      ex(1, 32'h400 + 32'(4 * (i - 1)), 32'(i), 1); ex(2, 0, 32'h1111_1111, 0);
      if (i == 4) ex(3, 0, 0, 0);
      req(1, i == 4, 32'(i));
      drain();
    end
    ex(1, 32'h410, 32'hA5, 1); ex(2, 0, 32'h1111_1111, 0); ex(3, 0, 0, 0);
    req(1, 1, 32'hA5);
    drain();
    // RA0 wrap at all-ones
    load(0, 32'h01FF_FFFF);
    rdata = 32'hCAFE_F00D;
    ex(0, 32'h7FFFFFC, 0, 1); ex(2, 0, 32'hCAFE_F00D, 0); ex(3, 0, 0, 0);
    req(0, 1, 0);
    drain();
    rdata = 32'h0BAD_F00D;
    ex(0, 32'h0, 0, 1); ex(2, 0, 32'h0BAD_F00D, 0); ex(3, 0, 0, 0);
    req(0, 1, 0);
    drain();
    // WA0 load coinciding with WA0 increment: load wins
    ex(1, 32'h414, 32'h7, 1); ex(2, 0, 32'h0BAD_F00D, 0);
    req(1, 0, 32'h7);
    tick();
    DSP_DSO = 32'h50; DSP_WA0W = 1;
    tick();
    DSP_WA0W = 0;
    drain();
    ex(1, 32'h140, 32'h8, 1); ex(2, 0, 32'h0BAD_F00D, 0); ex(3, 0, 0, 0);
    req(1, 1, 32'h8);
    drain();
    // abort: RUN drops during BUS, access completes, no ACK/END
    load(0, 32'h20);
    ack_delay = 3; rdata = 32'h3333_3333;
    ex(0, 32'h80, 0, 3);
    req(0, 1, 0);
    tick();
    DSP_DMA_RUN = 0;
    repeat (4) tick();
    DSP_DMA_RUN = 1;
    drain();
    repeat (4) tick();
    load(0, 32'h30);
    ack_delay = 1; rdata = 32'h4444_4444;
    ex(0, 32'hC0, 0, 1); ex(2, 0, 32'h4444_4444, 0); ex(3, 0, 0, 0);
    req(0, 1, 0);
    drain();
    // CE every 3rd clock
    ce_div = 3;
    tick();
    load(0, 32'h0001_2345);
    ack_delay = 2; rdata = 32'hDEAD_BEEF;
    ex(0, 32'h0048D14, 0, 6); ex(2, 0, 32'hDEAD_BEEF, 0); ex(3, 0, 0, 0);
    req(0, 1, 0);
    drain();
    // reset mid-access drops the strobe on the next edge
    no_ack = 1;
    ex(0, 32'h0048D18, 0, -1);
    req(0, 1, 0);
    for (int i = 0; i < 30 && !(MEM_RD || MEM_WR); i++) @(negedge CLK);
    chk("strobe_before_rst", 32'(MEM_RD), 1);
    RST = 1;
    @(negedge CLK);
    chk("strobe_after_rst", {30'd0, MEM_RD, MEM_WR}, 0);
    RST = 0;
    no_ack = 0; ce_div = 1;
    drain();
`ifdef SCU_DSP_DMA_TIMEOUT_EN
    load(0, 32'h200);
    no_ack = 1;
    ex(0, 32'h800, 0, 4); ex(2, 0, 32'h0, 0); ex(3, 0, 0, 0);
    req(0, 1, 0);
    drain();
    chk("err_set", 32'(ERR), 1);
    no_ack = 0; ack_delay = 1; rdata = 32'h12;
    ex(0, 32'h800, 0, 1); ex(2, 0, 32'h12, 0); ex(3, 0, 0, 0);
    req(0, 1, 0);
    drain();
    chk("err_sticky", 32'(ERR), 1);
    pulse_rst();
    chk("err_cleared", 32'(ERR), 0);
`else
    chk("err_tied", 32'(ERR), 0);
`endif
    repeat (5) tick();
    chk("queue_empty", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, fails);
    $fatal(1);
  end
endmodule
